// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types for pc_fetch: FSM states, queue entry, constants.
//            HALT exists only when FETCH_MISALIGN_CHECK_EN is defined.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int PC_INC  = 4;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {
    ST_RESET_IDLE = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT       = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_HALT       = 3'd4
  } fetch_state_e;
`else
  typedef enum logic [2:0] {
    ST_RESET_IDLE = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT       = 3'd2,
    ST_DRAIN      = 3'd3
  } fetch_state_e;
`endif

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_if
// Purpose  : Instruction-memory request/response and decode-side handshake.
// Revision : 1.0
// ============================================================================
interface pc_fetch_if #(
  parameter int XLEN = 32
);
  import fetch_pkg::*;

  logic               imem_req_valid;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [XLEN-1:0]    if_pc;
  logic               if_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Power-of-two FIFO of fetched {pc, instr} with synchronous flush.
// Revision : 1.0
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  fetch_entry_t     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Depth is a power of two, so pointers wrap at FIFO_DEPTH by overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Purpose  : PC register, single-outstanding imem fetch and decode queue.
//            FETCH_MISALIGN_CHECK_EN adds the sticky misaligned flag and HALT.
// Revision : 1.0
// ============================================================================
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcMux,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  pc_fetch_if.master      bus
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misaligned
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]  target;
  logic             redirect;
  logic             req_valid;
  logic             q_flush, q_push, q_pop, q_full, q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_din, q_dout;
  logic             unused_q_count;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic misalign_hit;

  assign target       = branch_target;
  assign misalign_hit = |branch_target[1:0];
  // HALT is terminal: later redirects are ignored until reset.
  assign redirect     = pcMux && (state_q != ST_HALT);
  assign misaligned   = mis_q;
`else
  logic unused_tgt_lsb;

  assign target         = {branch_target[XLEN-1:2], 2'b00};
  assign unused_tgt_lsb = ^branch_target[1:0];
  assign redirect       = pcMux;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tag_d     = tag_q;
    q_flush   = 1'b0;
    q_push    = 1'b0;
    req_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d     = mis_q;
`endif
    case (state_q)
      ST_RESET_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        req_valid = !stall && !pcMux && !q_full;
        if (req_valid && bus.imem_req_ready) begin
          tag_d   = pc_q;
          pc_d    = pc_q + XLEN'(PC_INC);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          q_push  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_rsp_valid) begin
          state_d = ST_FETCH;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_RESET_IDLE;
    endcase

    // A response landing with the redirect is consumed here, so nothing is
    // left in flight and DRAIN would otherwise wait forever.
    if (redirect) begin
      pc_d    = target;
      q_flush = 1'b1;
      q_push  = 1'b0;
      state_d = ((state_q == ST_WAIT || state_q == ST_DRAIN) && !bus.imem_rsp_valid)
                ? ST_DRAIN : ST_FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (misalign_hit) begin
        mis_d   = 1'b1;
        state_d = ST_HALT;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET_IDLE;
      pc_q    <= RESET_PC;
      tag_q   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign q_pop          = !q_empty && bus.if_ready;
  assign q_din.pc       = tag_q;
  assign q_din.instr    = bus.imem_rsp_data;
  assign unused_q_count = ^q_count;

  fetch_queue #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (q_flush),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = !q_empty;
  assign bus.if_instr       = q_dout.instr;
  assign bus.if_pc          = q_dout.pc;

endmodule
`default_nettype wire

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage that consumes the branch selector's `pcMux` decision. It holds the PC, issues single-outstanding requests to instruction memory, and buffers returned instructions in a small queue toward decode. Taken branches redirect the PC, flush the queue and discard any in-flight response. It sits between the branch selector in EX and the decode stage.

## Interface
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `FIFO_DEPTH`, 2, instruction-queue entries (power of two, ≥2)

- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `pcMux` in 1, redirect request from branch selector; 1 = take `branch_target`
- `branch_target` in XLEN, redirect address, valid when `pcMux`=1
- `stall` in 1, suppress new memory requests
- `imem_req_valid` out 1, request valid
- `imem_req_addr` out XLEN, request address (current fetch PC)
- `imem_req_ready` in 1, memory accepts request
- `imem_rsp_valid` in 1, response valid, ≥1 cycle after accept, in order
- `imem_rsp_data` in 32, instruction word
- `if_valid` out 1, queue head valid
- `if_instr` out 32, queue head instruction
- `if_pc` out XLEN, PC of `if_instr`
- `if_ready` in 1, decode consumes head
- `misaligned` out 1, sticky target-misaligned flag (only with macro)

## Operation
- States: RESET_IDLE, FETCH, WAIT, DRAIN, plus HALT (only with macro).
- RESET_IDLE → FETCH on the first clock after `rst_n` deasserts.
- FETCH: `imem_req_valid`=1 when not `stall`, not `pcMux`, and the queue has a free slot. On accept: record the PC as the in-flight tag, PC += 4 (mod 2^XLEN), go to WAIT.
- WAIT: on `imem_rsp_valid`, push {tag, data} into the queue and go to FETCH. No new request while waiting; one outstanding request at most.
- Redirect (`pcMux`=1) has priority over everything else in every state:
  - PC ← `branch_target`.
  - Queue is flushed.
  - If a request is outstanding, or is accepted in the same cycle, go to DRAIN. Otherwise go to FETCH.
- DRAIN: the next `imem_rsp_valid` is discarded, then go to FETCH. A redirect during DRAIN updates the PC and stays in DRAIN.
- `stall` blocks only request issue. Responses are still accepted and dequeue still works.
- Queue behaviour:
  - Dequeue when `if_valid && if_ready`.
  - Push and pop in the same cycle are legal at any occupancy.
  - A request is never issued when occupancy plus outstanding equals `FIFO_DEPTH`, so the queue cannot overflow.
- A response arriving in the same cycle as a redirect is discarded.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - `misaligned`=0, state RESET_IDLE.
- Earliest request: cycle 1 after reset release.
- Response to `if_valid`: 1 cycle (registered push).
- `imem_req_addr` is registered and shows `branch_target` in the cycle after a redirect.
- `if_valid` drops in the cycle after a redirect.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency.
- Asserting `rst_n` low mid-operation clears all state immediately and drops any outstanding response.

## Configuration
- Macro `FETCH_MISALIGN_CHECK_EN`.
- Defined: a redirect with `branch_target[1:0]`≠0 sets `misaligned`=1 (sticky until reset). The FSM enters HALT, where there are no requests and responses are ignored. The queue is flushed.
- Undefined: `branch_target[1:0]` is forced to 0, the `misaligned` port is absent, and there is no HALT state.

## Structure
- `fetch_pkg`:
  - State enum `fetch_state_e`.
  - `INSTR_W`=32.
  - `PC_INC`=4.
  - Queue entry struct {pc, instr}.
- Sub-module `fetch_queue`:
  - Parameterised FIFO with flush, push, pop, count and full/empty.
  - Pointer wrap at `FIFO_DEPTH`.

## Test plan
- Reset release, memory always ready with 1-cycle latency, `if_ready`=1:
  - Requests go to 0x0, 0x4, 0x8.
  - `if_pc` sequence is 0x0, 0x4, 0x8 with the matching data.
- `if_ready`=0 for 6 cycles:
  - Exactly 2 entries are queued and requests stop.
  - Raising `if_ready` resumes with PC 0x8 next.
- `pcMux`=1 with target 0x100 while waiting on the response for 0x10:
  - The 0x10 response is discarded.
  - The next `if_pc` is 0x100.
- `stall`=1 for 4 cycles while an older request's response arrives:
  - The response is enqueued.
  - No new request is issued until `stall`=0.
- PC at 0xFFFF_FFFC fetches, then the next request address is 0x0000_0000 (wrap).
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x102:
  - `misaligned`=1 next cycle.
  - `imem_req_valid` stays 0 until reset.
